// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS-style main controller: Moore FSM driving datapath selects and
// write enables, plus a sticky flag raised when DECODE sees an unsupported opcode.
module main_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSrc,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ORIEX  = 4'd9,
        S_ORIWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t state_reg, state_next;
    logic   illegal_reg, illegal_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
        end
    end

    // op/funct only matter in DECODE and MEMADR; every other state ignores them.
    always_comb begin
        state_next   = S_FETCH;
        illegal_next = illegal_reg;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = (funct == FN_JR) ? S_JR : S_REX;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ORI:       state_next = S_ORIEX;
                    OP_J:         state_next = S_JUMP;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        state_next   = S_FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_REX:    state_next = S_RWB;
            S_ORIEX:  state_next = S_ORIWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUop       = 2'b00;
        PCSrc       = 2'b00;
        case (state_reg)
            S_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_REX: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSrc       = 2'b01;
            end
            S_ORIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = 2'b11;
            end
            S_ORIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            // PC already holds PC+4 here, so MemtoReg=10 links the return address.
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSrc    = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
            end
            S_JR: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b11;
            end
            default: ;
        endcase
        // Architectural side effects must not fire while reset is held.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign state   = state_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Self-checking bench for main_ctrl_fsm: directed instruction table, reset corner
// cases, then random instructions checked against a per-instruction state-path model.
module tb_main_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA, illegal;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUop, PCSrc;
    logic [3:0] state;

    main_ctrl_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSrc(PCSrc),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit ill_model = 1'b0;
    logic [16:0] ctrl_exp [16];

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        int          len;
        logic [19:0] seq;
        bit          ill;
    } vec_t;
    vec_t vecs [9];

    function automatic logic [16:0] mk(input logic pcw, pcwc, iord, mw, irw,
                                       input logic [1:0] rd, m2r, input logic rw, sa,
                                       input logic [1:0] sb, aop, ps);
        return {pcw, pcwc, iord, mw, irw, rd, m2r, rw, sa, sb, aop, ps};
    endfunction

    function automatic logic [16:0] outs();
        return {PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSrc};
    endfunction

    // Instruction-level model: state path and illegal-ness from the opcode rules.
    function automatic void model(input logic [5:0] o, input logic [5:0] f,
                                  output int len, output logic [19:0] s, output bit ill);
        ill = 1'b0;
        case (o)
            6'h23: begin len = 5; s = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}; end
            6'h2B: begin len = 4; s = {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}; end
            6'h00: begin
                if (f == 6'h08) begin len = 3; s = {8'd0, 4'd13, 4'd1, 4'd0}; end
                else begin len = 4; s = {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}; end
            end
            6'h04: begin len = 3; s = {8'd0, 4'd8, 4'd1, 4'd0}; end
            6'h0D: begin len = 4; s = {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}; end
            6'h02: begin len = 3; s = {8'd0, 4'd11, 4'd1, 4'd0}; end
            6'h03: begin len = 3; s = {8'd0, 4'd12, 4'd1, 4'd0}; end
            default: begin len = 2; s = {12'd0, 4'd1, 4'd0}; ill = 1'b1; end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1 with the DUT in FETCH; leaves it at posedge+1 of the next FETCH.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int len,
                             input logic [19:0] seq, input bit ill, input bit garble);
        logic [3:0] es;
        for (int i = 0; i < len; i++) begin
            es = seq[4*i +: 4];
            if (garble && es != 4'd1 && es != 4'd2) begin
                op = 6'($urandom); funct = 6'($urandom);
            end else begin
                op = o; funct = f;
            end
            #1;
            chk("state", 32'(state), 32'(es));
            chk("ctrl", 32'(outs()), 32'(ctrl_exp[es]));
            chk("illegal", 32'(illegal), 32'(ill_model));
            @(posedge clk); #1;
            if (es == 4'd1 && ill) ill_model = 1'b1;
        end
        $display("instr op=%b funct=%b cycles=%0d illegal=%0b", o, f, len, illegal);
    endtask

    initial begin
        int          len;
        logic [19:0] s;
        bit          ill;
        logic [5:0]  ro, rf;
        logic [5:0]  ops [8];

        for (int i = 0; i < 16; i++) ctrl_exp[i] = '0;
        ctrl_exp[0]  = mk(1,0,0,0,1, 2'd0,2'd0,0,0, 2'd1,2'd0,2'd0);
        ctrl_exp[1]  = mk(0,0,0,0,0, 2'd0,2'd0,0,0, 2'd3,2'd0,2'd0);
        ctrl_exp[2]  = mk(0,0,0,0,0, 2'd0,2'd0,0,1, 2'd2,2'd0,2'd0);
        ctrl_exp[3]  = mk(0,0,1,0,0, 2'd0,2'd0,0,0, 2'd0,2'd0,2'd0);
        ctrl_exp[4]  = mk(0,0,0,0,0, 2'd0,2'd1,1,0, 2'd0,2'd0,2'd0);
        ctrl_exp[5]  = mk(0,0,1,1,0, 2'd0,2'd0,0,0, 2'd0,2'd0,2'd0);
        ctrl_exp[6]  = mk(0,0,0,0,0, 2'd0,2'd0,0,1, 2'd0,2'd2,2'd0);
        ctrl_exp[7]  = mk(0,0,0,0,0, 2'd1,2'd0,1,0, 2'd0,2'd0,2'd0);
        ctrl_exp[8]  = mk(0,1,0,0,0, 2'd0,2'd0,0,1, 2'd0,2'd1,2'd1);
        ctrl_exp[9]  = mk(0,0,0,0,0, 2'd0,2'd0,0,1, 2'd2,2'd3,2'd0);
        ctrl_exp[10] = mk(0,0,0,0,0, 2'd0,2'd0,1,0, 2'd0,2'd0,2'd0);
        ctrl_exp[11] = mk(1,0,0,0,0, 2'd0,2'd0,0,0, 2'd0,2'd0,2'd2);
        ctrl_exp[12] = mk(1,0,0,0,0, 2'd2,2'd2,1,0, 2'd0,2'd0,2'd2);
        ctrl_exp[13] = mk(1,0,0,0,0, 2'd0,2'd0,0,0, 2'd0,2'd0,2'd3);

        vecs[0] = '{6'b100011, 6'b000000, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b0};
        vecs[1] = '{6'b000000, 6'b100011, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 1'b0};
        vecs[2] = '{6'b000000, 6'b001000, 3, {8'd0, 4'd13, 4'd1, 4'd0}, 1'b0};
        vecs[3] = '{6'b000100, 6'b000000, 3, {8'd0, 4'd8, 4'd1, 4'd0}, 1'b0};
        vecs[4] = '{6'b000011, 6'b000000, 3, {8'd0, 4'd12, 4'd1, 4'd0}, 1'b0};
        vecs[5] = '{6'b101011, 6'b000000, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 1'b0};
        vecs[6] = '{6'b111111, 6'b000000, 2, {12'd0, 4'd1, 4'd0}, 1'b1};
        vecs[7] = '{6'b001101, 6'b000000, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}, 1'b0};
        vecs[8] = '{6'b000010, 6'b000000, 3, {8'd0, 4'd11, 4'd1, 4'd0}, 1'b0};

        reset = 1'b1; op = '0; funct = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        chk("reset_pcwrite_forced", 32'(PCWrite), 32'd0);
        chk("reset_irwrite_forced", 32'(IRWrite), 32'd0);
        chk("reset_alusrcb", 32'(ALUSrcB), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_instr(vecs[i].op, vecs[i].funct, vecs[i].len, vecs[i].seq, vecs[i].ill, 1'b1);
        chk("illegal_sticky", 32'(illegal), 32'd1);

        // Reset asserted mid-store, with illegal already set.
        op = 6'b101011; funct = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("memwr_reached", 32'(state), 32'd5);
        chk("memwr_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("memwr_reset_memwrite", 32'(MemWrite), 32'd0);
        chk("memwr_reset_iord", 32'(IorD), 32'd1);
        @(posedge clk); #1;
        chk("midreset_state", 32'(state), 32'd0);
        chk("midreset_illegal", 32'(illegal), 32'd0);
        chk("midreset_pcwrite", 32'(PCWrite), 32'd0);
        reset = 1'b0;
        ill_model = 1'b0;
        $display("reset in MEMWR: state=%0d illegal=%0b", state, illegal);

        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h0D, 6'h02, 6'h03, 6'h3F};
        for (int n = 0; n < 60; n++) begin
            ro = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            rf = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
            model(ro, rf, len, s, ill);
            run_instr(ro, rf, len, s, ill, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
